// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM states, oversampling
// constants and the baud divider calculation.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_t;

    localparam int OS_RATE = 16;
    localparam int OS_W    = 4;

    // Oversample ticks at which the line is sampled for the majority vote.
    localparam logic [OS_W-1:0] SAMPLE_A = 4'd7;
    localparam logic [OS_W-1:0] SAMPLE_B = 4'd8;
    localparam logic [OS_W-1:0] SAMPLE_C = 4'd9;
    localparam logic [OS_W-1:0] OS_LAST  = 4'd15;

    // Clock cycles per oversample tick, truncated.
    function automatic int os_div(input int freq_mhz, input int bauds);
        return (freq_mhz * 1000000) / (bauds * OS_RATE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// Small synchronous first-word-fall-through FIFO. A push into a full FIFO
// is dropped unless a pop happens in the same cycle.
module uart_rx_fifo_buf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array; written only when a push is accepted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; occupancy is tracked separately so full and empty are unambiguous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote,
// feeding a FWFT byte FIFO drained by the CPU. Sticky framing/overrun flags.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int FREQ_MHZ = 48,
    parameter int BAUDS    = 115200,
    parameter int DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   rd,
    input  logic                   clr_err,
    output logic [7:0]             rx_data,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int OS_DIV = os_div(FREQ_MHZ, BAUDS);
    localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);

    generate
        if (OS_DIV < 2) begin : g_div_check
            $error("uart_rx_fifo: clock too slow for 16x oversampling at this baud rate");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [1:0]      sync_q;
    logic            rxs;
    rx_state_t       state;
    logic [DIV_W-1:0] div_cnt;
    logic [OS_W-1:0] os_cnt;
    logic            active;
    logic            tick;
    logic            sample_a;
    logic            sample_b;
    logic            bit_now;
    logic            eval;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            push;
    logic            frame_evt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

    assign rxs       = sync_q[1];
    assign active    = (state != IDLE) && (state != WAIT_HI);
    assign tick      = active && (div_cnt == DIV_LAST);
    assign bit_now   = (sample_a & sample_b) | (sample_a & rxs) | (sample_b & rxs);
    assign eval      = tick && (os_cnt == SAMPLE_C);
    assign push      = (state == STOP) && eval && bit_now;
    assign frame_evt = (state == STOP) && eval && !bit_now;
    assign drop      = push && fifo_full && !rd;
    assign valid     = !fifo_empty;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Oversample tick generator; held at zero while waiting so phase locks to the start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (!active) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= os_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Frame FSM: start validation, data shift-in, stop check and break wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            sample_a <= 1'b1;
            sample_b <= 1'b1;
        end else begin
            if (tick && os_cnt == SAMPLE_A) begin
                sample_a <= rxs;
            end
            if (tick && os_cnt == SAMPLE_B) begin
                sample_b <= rxs;
            end
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (eval && bit_now) begin
                        state <= IDLE;
                    end else if (tick && os_cnt == OS_LAST) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (eval) begin
                        shreg <= {bit_now, shreg[7:1]};
                    end
                    if (tick && os_cnt == OS_LAST) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (eval) begin
                        state <= bit_now ? IDLE : WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error event takes priority over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_evt) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_rx_fifo_buf #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (rd),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a random
// phase, all checked against a queue-based model of the receive path.
module tb_uart_rx_fifo;

    localparam int FREQ_MHZ = 32;
    localparam int BAUDS    = 1000000;
    localparam int DEPTH    = 8;
    localparam int BIT_CLK  = 32;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          rd;
    logic          clr_err;
    logic [7:0]    rx_data;
    logic          valid;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;

    int vectors     = 0;
    int miscompares = 0;
    int t1_wait;
    int npop;

    logic [7:0] model_q[$];
    logic       m_ferr;
    logic       m_ovr;
    logic [7:0] rnd_byte;
    logic       rnd_stop;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .FREQ_MHZ (FREQ_MHZ),
        .BAUDS    (BAUDS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd        (rd),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .valid     (valid),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [7:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        checkOutput({tag, ".count"},     32'(count),     32'(model_q.size()));
        checkOutput({tag, ".valid"},     32'(valid),     32'(model_q.size() != 0));
        checkOutput({tag, ".rx_data"},   32'(rx_data),   32'(head));
        checkOutput({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
        checkOutput({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
    endtask

    // Reference behaviour for one complete frame reaching the stop bit.
    function automatic void modelFrame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) begin
            m_ferr = 1'b1;
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(b);
        end else begin
            m_ovr = 1'b1;
        end
    endfunction

    // Drive one 8N1 frame, LSB first; rx is left at the stop level.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop_val;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic popAndCheck(input string tag);
        logic [7:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        checkOutput({tag, ".pop"}, 32'(rx_data), 32'(head));
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (model_q.size() != 0) begin
            void'(model_q.pop_front());
        end
    endtask

    task automatic pulseClr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
        m_ferr = 1'b0; m_ovr = 1'b0;
        idle(3);
        checkModel("reset");
        reset = 1'b0;
        idle(5);
        checkModel("post_reset");

        // Clean frame, valid must not appear before mid-stop and must appear shortly after.
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                repeat (9 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
                checkOutput("t1.valid_at_mid_stop", 32'(valid), 32'd0);
                t1_wait = 0;
                while (!valid && t1_wait < 12) begin
                    @(negedge clk);
                    t1_wait++;
                end
                checkOutput("t1.valid_latency", 32'(valid), 32'd1);
            end
        join
        modelFrame(8'hA5, 1'b1);
        idle(4);
        checkModel("t1");
        popAndCheck("t1");
        checkModel("t1.drained");

        // Short low glitch is rejected.
        rx = 1'b0;
        idle(8);
        rx = 1'b1;
        idle(3 * BIT_CLK);
        checkModel("t2");

        // Framing error followed by a break, then recovery.
        applyStimulus(8'h3C, 1'b0);
        modelFrame(8'h3C, 1'b0);
        idle(200);
        checkModel("t3.break");
        rx = 1'b1;
        idle(BIT_CLK);
        applyStimulus(8'h55, 1'b1);
        modelFrame(8'h55, 1'b1);
        idle(4);
        checkModel("t3.recovered");
        pulseClr();
        checkModel("t3.cleared");
        popAndCheck("t3");

        // Nine bytes with no reads: the ninth overruns.
        for (int b = 1; b <= 9; b++) begin
            applyStimulus(8'(b), 1'b1);
            modelFrame(8'(b), 1'b1);
        end
        idle(4);
        checkModel("t4.full");
        for (int i = 0; i < 8; i++) begin
            popAndCheck("t4");
        end
        checkModel("t4.empty");
        pulseClr();
        checkModel("t4.cleared");

        // Read coinciding with the push into a full FIFO.
        for (int b = 1; b <= 8; b++) begin
            applyStimulus(8'(b), 1'b1);
            modelFrame(8'(b), 1'b1);
        end
        checkModel("t5.full");
        fork
            applyStimulus(8'h99, 1'b1);
            begin
                repeat (9 * BIT_CLK + 22) @(negedge clk);
                checkOutput("t5.head_at_push", 32'(rx_data), 32'h01);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        void'(model_q.pop_front());
        modelFrame(8'h99, 1'b1);
        idle(4);
        checkModel("t5.after");
        for (int i = 0; i < 8; i++) begin
            popAndCheck("t5");
        end
        checkModel("t5.empty");

        // Reset in the middle of a frame discards everything.
        applyStimulus(8'h77, 1'b1);
        modelFrame(8'h77, 1'b1);
        idle(4);
        checkModel("t6.preload");
        fork
            applyStimulus(8'hFF, 1'b1);
            begin
                repeat (5 * BIT_CLK + 10) @(negedge clk);
                reset = 1'b1;
                idle(2);
                model_q.delete();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
                checkModel("t6.in_reset");
                reset = 1'b0;
            end
        join
        idle(BIT_CLK);
        applyStimulus(8'h12, 1'b1);
        modelFrame(8'h12, 1'b1);
        idle(4);
        checkModel("t6.after");

        // Random frames, random stop validity and random reads.
        pulseClr();
        for (int i = 0; i < 10; i++) begin
            rnd_byte = 8'($urandom);
            rnd_stop = ($urandom_range(0, 3) != 0);
            applyStimulus(rnd_byte, rnd_stop);
            modelFrame(rnd_byte, rnd_stop);
            rx = 1'b1;
            idle($urandom_range(4, 20));
            checkModel("rnd");
            npop = $urandom_range(0, 2);
            for (int j = 0; j < npop; j++) begin
                popAndCheck("rnd");
            end
        end
        checkModel("rnd.final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
